// File: rtl/abr_ram_stream_pkg.sv
// Shared types for the RAM read-stream block.
// State encoding and FIFO sizing.
package abr_ram_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } rd_state_e;

   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W = 2;

endpackage

// File: rtl/abr_1r1w_ram.sv
// Simple 1R1W RAM with registered read data.
// Read data holds its value while re_i is low.
module abr_1r1w_ram #(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Write port and registered read port.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/abr_ram_rd_stream.sv
// Burst reader: issues RAM reads and streams the words
// out through a 2-entry skid FIFO with valid/ready.
module abr_ram_rd_stream
   import abr_ram_stream_pkg::*;
#(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_b,
   input  logic                  zeroize_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH:0]   len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  ram_re_o,
   output logic [ADDR_WIDTH-1:0] ram_raddr_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  last_o
);

   localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

   rd_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   rd_left_q, rd_left_d;
   logic [ADDR_WIDTH:0]   out_left_q, out_left_d;
   logic                  infl_q;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic                  wptr_q, rptr_q;
   logic [FIFO_CNT_W-1:0] cnt_q;

   logic       pop;
   logic       push;
   logic       re;
   logic       done;
   logic [2:0] lvl;

   assign pop  = (cnt_q != '0) && ready_i;
   assign push = infl_q;

   // Occupancy after this cycle's pop, counting the read in flight.
   assign lvl = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
   assign re  = (state_q == ST_READ) && (lvl < 3'd2) && !zeroize_i;

   // Next-state, address and counter logic.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rd_left_d  = rd_left_q;
      out_left_d = out_left_q;
      done       = 1'b0;
      if (pop) out_left_d = out_left_q - CNT_ONE;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               addr_d     = base_addr_i;
               rd_left_d  = len_i;
               out_left_d = len_i;
               state_d    = (len_i == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            if (re) begin
               addr_d    = addr_q + ADDR_WIDTH'(1);
               rd_left_d = rd_left_q - CNT_ONE;
               if (rd_left_q == CNT_ONE) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && out_left_q == CNT_ONE) state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (zeroize_i) begin
         state_d    = ST_IDLE;
         addr_d     = '0;
         rd_left_d  = '0;
         out_left_d = '0;
         done       = 1'b0;
      end
   end

   // State, address, counters and in-flight flag.
   always_ff @(posedge clk_i or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         rd_left_q  <= '0;
         out_left_q <= '0;
         infl_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rd_left_q  <= rd_left_d;
         out_left_q <= out_left_d;
         infl_q     <= re;
      end
   end

   // FIFO pointers and occupancy; zeroize drops in-flight data.
   always_ff @(posedge clk_i or negedge rst_b) begin
      if (!rst_b) begin
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         cnt_q  <= '0;
      end else if (zeroize_i) begin
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (push) wptr_q <= ~wptr_q;
         if (pop) rptr_q <= ~rptr_q;
         cnt_q <= cnt_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
      end
   end

   // FIFO storage captures read data the cycle after each read.
   always_ff @(posedge clk_i or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (push && !zeroize_i) begin
         mem_q[wptr_q] <= ram_rdata_i;
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done;
   assign ram_re_o    = re;
   assign ram_raddr_o = addr_q;
   assign valid_o     = (cnt_q != '0);
   assign data_o      = mem_q[rptr_q];
   assign last_o      = valid_o && (out_left_q == CNT_ONE);

endmodule

// File: tb/tb_abr_ram_rd_stream.sv
// Directed bench for abr_ram_rd_stream paired with
// abr_1r1w_ram holding RAM[i] = i + 0x100.
module tb_abr_ram_rd_stream;

   localparam int DEPTH = 64;
   localparam int DW    = 32;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          rst_b;
   logic          zeroize_i;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [AW:0]   len_i;
   logic          busy_o;
   logic          done_o;
   logic          ram_re_o;
   logic [AW-1:0] ram_raddr_o;
   logic [DW-1:0] ram_rdata;
   logic          valid_o;
   logic          ready_i;
   logic [DW-1:0] data_o;
   logic          last_o;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   abr_1r1w_ram #(
      .DEPTH(DEPTH), .DATA_WIDTH(DW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .re_i    (ram_re_o),
      .raddr_i (ram_raddr_o),
      .rdata_o (ram_rdata)
   );

   abr_ram_rd_stream #(
      .DEPTH(DEPTH), .DATA_WIDTH(DW)
   ) dut (
      .clk_i       (clk),
      .rst_b       (rst_b),
      .zeroize_i   (zeroize_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .ram_re_o    (ram_re_o),
      .ram_raddr_o (ram_raddr_o),
      .ram_rdata_i (ram_rdata),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .data_o      (data_o),
      .last_o      (last_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic burst(input int base, input int len,
                        input bit rnd, input bit poke);
      int nre = 0, npop = 0, occ = 0;
      int first_re = -1, first_val = -1;
      int done_c = -1, done_cnt = 0, last_pop_c = -1;
      bit infl = 1'b0, prev_stall = 1'b0, pop;
      logic [DW-1:0] prev_data = '0;
      start_i     = 1'b1;
      base_addr_i = AW'(base);
      len_i       = (AW+1)'(len);
      ready_i     = 1'b1;
      #1;
      chk("idle_busy", 32'(busy_o), 32'd0);
      tick();
      start_i = 1'b0;
      for (int c = 1; c < len * 4 + 20 && done_c < 0; c++) begin
         if (poke && c == 2) begin
            start_i     = 1'b1;
            base_addr_i = AW'(33);
            len_i       = (AW+1)'(5);
         end else begin
            start_i = 1'b0;
         end
         ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         pop = valid_o && ready_i;
         if (ram_re_o) begin
            if (first_re < 0) first_re = c;
            chk("re_addr", 32'(ram_raddr_o), 32'((base + nre) % DEPTH));
            chk("re_level", 32'(occ + int'(infl) - int'(pop) < 2), 32'd1);
            nre++;
         end
         if (valid_o && first_val < 0) first_val = c;
         chk("valid_model", 32'(valid_o), 32'(occ != 0));
         if (prev_stall) chk("stall_stable", data_o, prev_data);
         if (pop) begin
            chk("data", data_o, 32'h100 + 32'((base + npop) % DEPTH));
            chk("last", 32'(last_o), 32'(npop == len - 1));
            npop++;
            last_pop_c = c;
         end else if (!valid_o) begin
            chk("last_idle", 32'(last_o), 32'd0);
         end
         if (done_o) begin
            done_cnt++;
            done_c = c;
         end
         prev_stall = valid_o && !ready_i;
         prev_data  = data_o;
         occ  = occ + int'(infl) - int'(pop);
         infl = ram_re_o;
         tick();
      end
      start_i = 1'b0;
      #1;
      chk("post_idle", {30'd0, busy_o, done_o}, 32'd0);
      chk("reads", 32'(nre), 32'(len));
      chk("pops", 32'(npop), 32'(len));
      chk("done_cnt", 32'(done_cnt), 32'd1);
      if (len == 0) begin
         chk("done_lat0", 32'(done_c), 32'd1);
         chk("no_valid", 32'(first_val), 32'hffff_ffff);
      end else begin
         chk("re_lat", 32'(first_re), 32'd1);
         chk("valid_lat", 32'(first_val), 32'd3);
         chk("done_lat", 32'(done_c), 32'(last_pop_c + 1));
         if (!rnd)
            chk("no_gap", 32'(last_pop_c - first_val), 32'(len - 1));
      end
      tick();
   endtask

   task automatic abort(input bit use_rst);
      int npop = 0;
      start_i     = 1'b1;
      base_addr_i = '0;
      len_i       = (AW+1)'(10);
      ready_i     = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (valid_o && ready_i) npop++;
         if (npop == 3) break;
         tick();
      end
      chk("abort_pops", 32'(npop), 32'd3);
      tick();
      if (use_rst) rst_b = 1'b0;
      else zeroize_i = 1'b1;
      #1;
      if (use_rst) chk("rst_async_valid", 32'(valid_o), 32'd0);
      tick();
      zeroize_i = 1'b0;
      rst_b     = 1'b1;
      #1;
      chk("abort_state", {29'd0, valid_o, busy_o, done_o}, 32'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("abort_quiet", {29'd0, done_o, valid_o, ram_re_o}, 32'd0);
      end
      tick();
   endtask

   initial begin
      rst_b       = 1'b0;
      zeroize_i   = 1'b0;
      start_i     = 1'b0;
      base_addr_i = '0;
      len_i       = '0;
      ready_i     = 1'b0;
      we          = 1'b0;
      waddr       = '0;
      wdata       = '0;
      #1;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_re", 32'(ram_re_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_last", 32'(last_o), 32'd0);
      chk("rst_raddr", 32'(ram_raddr_o), 32'd0);
      chk("rst_data", data_o, 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         we    = 1'b1;
         waddr = AW'(i);
         wdata = 32'h100 + 32'(i);
         tick();
      end
      we = 1'b0;
      rst_b = 1'b1;
      tick();
      burst(4, 8, 1'b0, 1'b0);
      burst(62, 4, 1'b0, 1'b0);
      burst(0, 16, 1'b1, 1'b1);
      burst(0, 0, 1'b0, 1'b0);
      burst(10, 64, 1'b0, 1'b0);
      abort(1'b0);
      burst(0, 2, 1'b0, 1'b0);
      abort(1'b1);
      burst(0, 2, 1'b0, 1'b0);
      zeroize_i   = 1'b1;
      start_i     = 1'b1;
      base_addr_i = AW'(5);
      len_i       = (AW+1)'(3);
      tick();
      zeroize_i = 1'b0;
      start_i   = 1'b0;
      #1;
      chk("zeroize_prio", {30'd0, busy_o, ram_re_o}, 32'd0);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
